// File: rtl/iob_timer_mc.sv
// Multi-channel down-counting timer with a shared prescaler.
// Each channel is one-shot or auto-reload, with a sticky expiry flag and a masked ORed interrupt.
module iob_timer_mc #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned PRESC_W = 16
) (
  input  logic                     clk_i,
  input  logic                     cke_i,
  input  logic                     arst_i,
  input  logic                     soft_rst_i,
  input  logic [PRESC_W-1:0]       presc_i,
  input  logic [N_CH-1:0]          en_i,
  input  logic [N_CH-1:0]          periodic_i,
  input  logic [N_CH*DATA_W-1:0]   reload_i,
  input  logic [N_CH-1:0]          load_i,
  input  logic [N_CH-1:0]          irq_en_i,
  input  logic [N_CH-1:0]          irq_ack_i,
  input  logic                     sample_i,
  output logic [N_CH*DATA_W-1:0]   count_o,
  output logic [N_CH*DATA_W-1:0]   sample_o,
  output logic [N_CH-1:0]          expired_o,
  output logic                     irq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_t;

  logic [PRESC_W-1:0]           presc_q, presc_d;
  logic                         tick;
  ch_state_t                    state_q [N_CH];
  ch_state_t                    state_d [N_CH];
  logic [N_CH-1:0][DATA_W-1:0]  count_q, count_d;
  logic [N_CH-1:0][DATA_W-1:0]  sample_q, sample_d;
  logic [N_CH-1:0]              expired_q, expired_d;

  // Shared prescaler: advances only while at least one channel is enabled.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (|en_i) begin
      if (presc_q == presc_i) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  // Per-channel next state; load beats tick, a new expiry beats ack.
  always_comb begin
    for (int k = 0; k < int'(N_CH); k++) begin
      state_d[k]   = state_q[k];
      count_d[k]   = count_q[k];
      expired_d[k] = expired_q[k] & ~irq_ack_i[k];
      if (load_i[k]) begin
        count_d[k] = reload_i[k*DATA_W +: DATA_W];
        state_d[k] = RUN;
      end else if (tick && en_i[k] && (state_q[k] == RUN)) begin
        if (count_q[k] != '0) begin
          count_d[k] = count_q[k] - DATA_W'(1);
        end else begin
          expired_d[k] = 1'b1;
          if (periodic_i[k]) begin
            count_d[k] = reload_i[k*DATA_W +: DATA_W];
          end else begin
            state_d[k] = DONE;
          end
        end
      end
    end
  end

  // Capture reflects the pre-update counts of this edge.
  always_comb begin
    sample_d = sample_q;
    if (sample_i) begin
      sample_d = count_q;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      presc_q   <= '0;
      count_q   <= '0;
      sample_q  <= '0;
      expired_q <= '0;
      for (int k = 0; k < int'(N_CH); k++) begin
        state_q[k] <= IDLE;
      end
    end else if (cke_i) begin
      if (soft_rst_i) begin
        presc_q   <= '0;
        count_q   <= '0;
        sample_q  <= '0;
        expired_q <= '0;
        for (int k = 0; k < int'(N_CH); k++) begin
          state_q[k] <= IDLE;
        end
      end else begin
        presc_q   <= presc_d;
        count_q   <= count_d;
        sample_q  <= sample_d;
        expired_q <= expired_d;
        for (int k = 0; k < int'(N_CH); k++) begin
          state_q[k] <= state_d[k];
        end
      end
    end
  end

  assign count_o   = count_q;
  assign sample_o  = sample_q;
  assign expired_o = expired_q;
  assign irq_o     = |(expired_q & irq_en_i);

endmodule

// File: tb/tb_iob_timer_mc.sv
// Directed self-checking bench for iob_timer_mc with hand-computed expectations.
module tb_iob_timer_mc;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_CH    = 4;
  localparam int unsigned PRESC_W = 16;

  logic                   clk;
  logic                   cke;
  logic                   arst;
  logic                   soft_rst;
  logic [PRESC_W-1:0]     presc;
  logic [N_CH-1:0]        en;
  logic [N_CH-1:0]        periodic;
  logic [N_CH*DATA_W-1:0] reload;
  logic [N_CH-1:0]        load;
  logic [N_CH-1:0]        irq_en;
  logic [N_CH-1:0]        irq_ack;
  logic                   sample;
  logic [N_CH*DATA_W-1:0] count;
  logic [N_CH*DATA_W-1:0] sample_val;
  logic [N_CH-1:0]        expired;
  logic                   irq;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  iob_timer_mc #(.DATA_W(DATA_W), .N_CH(N_CH), .PRESC_W(PRESC_W)) dut (
    .clk_i      (clk),
    .cke_i      (cke),
    .arst_i     (arst),
    .soft_rst_i (soft_rst),
    .presc_i    (presc),
    .en_i       (en),
    .periodic_i (periodic),
    .reload_i   (reload),
    .load_i     (load),
    .irq_en_i   (irq_en),
    .irq_ack_i  (irq_ack),
    .sample_i   (sample),
    .count_o    (count),
    .sample_o   (sample_val),
    .expired_o  (expired),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Steps until the flag of channel k rises or the budget runs out.
  task automatic wait_exp(input int k, input int limit, output int cycles);
    cycles = 0;
    while (!expired[k] && cycles < limit) begin
      step(1);
      cycles++;
    end
  endtask

  task automatic do_reset();
    arst     = 1'b1;
    en       = '0;
    load     = '0;
    periodic = '0;
    irq_en   = '0;
    irq_ack  = '0;
    sample   = 1'b0;
    soft_rst = 1'b0;
    cke      = 1'b1;
    reload   = '0;
    step(1);
    arst = 1'b0;
    step(1);
  endtask

  initial begin
    int c;
    int t0, t1, t2, ref_c;
    logic all_zero;

    arst = 1'b1; cke = 1'b1; soft_rst = 1'b0; presc = '0; en = '0; periodic = '0;
    reload = '0; load = '0; irq_en = '0; irq_ack = '0; sample = 1'b0;
    #1;
    check("rst_count",   128'(count), 128'(0));
    check("rst_sample",  128'(sample_val), 128'(0));
    check("rst_expired", 128'(expired), 128'(0));
    check("rst_irq",     128'(irq), 128'(0));
    step(2);
    arst = 1'b0;
    all_zero = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (count != '0 || expired != '0) all_zero = 1'b0;
    end
    check("idle_100_stays_zero", 128'(all_zero), 128'(1));
    check("idle_count", 128'(count), 128'(0));

    // Periodic channel 0, presc 3, reload 4: period 20 cycles
    do_reset();
    presc = 16'd3; reload[0 +: 32] = 32'd4; periodic = 4'b0001; en = 4'b0001; load = 4'b0001;
    step(1);
    load = '0;
    check("per_load_count", 128'(count[0 +: 32]), 128'(4));
    wait_exp(0, 100, c);
    t1 = cyc;
    check("per_first_expiry", 128'(c), 128'(19));
    check("per_reloaded", 128'(count[0 +: 32]), 128'(4));
    step(5);
    check("per_sticky", 128'(expired[0]), 128'(1));
    irq_ack = 4'b0001; step(1); irq_ack = '0;
    check("per_ack_clears", 128'(expired[0]), 128'(0));
    wait_exp(0, 100, c);
    t2 = cyc;
    check("per_interval", 128'(t2 - t1), 128'(20));
    step(19);
    irq_ack = 4'b0001; step(1); irq_ack = '0;
    check("per_ack_vs_set", 128'(expired[0]), 128'(1));
    check("per_irq_masked", 128'(irq), 128'(0));
    irq_ack = 4'b0001; step(1); irq_ack = '0;
    check("per_ack2", 128'(expired[0]), 128'(0));

    // One-shot channel 1, presc 0, reload 7
    do_reset();
    presc = 16'd0; reload[32 +: 32] = 32'd7; periodic = '0; en = 4'b0010; load = 4'b0010;
    step(1);
    load = '0;
    wait_exp(1, 50, c);
    check("os_expiry", 128'(c), 128'(8));
    check("os_count_zero", 128'(count[32 +: 32]), 128'(0));
    irq_ack = 4'b0010; step(1); irq_ack = '0;
    step(20);
    check("os_done_no_reexpire", 128'(expired[1]), 128'(0));
    check("os_done_holds", 128'(count[32 +: 32]), 128'(0));
    reload[32 +: 32] = 32'd3; load = 4'b0010;
    step(1);
    load = '0;
    check("os_restart_count", 128'(count[32 +: 32]), 128'(3));
    wait_exp(1, 50, c);
    check("os_restart_expiry", 128'(c), 128'(4));

    // Reference run, then the same run with a 10-cycle pause and 5-cycle cke gap
    do_reset();
    presc = 16'd1; reload[0 +: 32] = 32'd9; en = 4'b0001; load = 4'b0001;
    step(1);
    load = '0;
    wait_exp(0, 100, ref_c);
    check("ref_expiry", 128'(ref_c), 128'(19));
    do_reset();
    presc = 16'd1; reload[0 +: 32] = 32'd9; en = 4'b0001; load = 4'b0001;
    step(1);
    load = '0;
    t0 = cyc;
    step(6);
    en = '0; step(10); en = 4'b0001;
    step(3);
    cke = 1'b0; step(5); cke = 1'b1;
    wait_exp(0, 100, c);
    check("pause_cke_total", 128'(cyc - t0), 128'(34));
    check("pause_cke_vs_ref", 128'(cyc - t0), 128'(ref_c + 15));

    // Sample coincident with decrement captures pre-decrement values
    do_reset();
    presc = 16'd0; en = 4'b1111;
    reload = {32'd300, 32'd200, 32'd100, 32'd9};
    load = 4'b1111;
    step(1);
    load = '0; sample = 1'b1;
    step(1);
    sample = 1'b0;
    check("smp_capture", 128'(sample_val), {32'd300, 32'd200, 32'd100, 32'd9});
    check("smp_count_after", 128'(count), {32'd299, 32'd199, 32'd99, 32'd8});

    // Interrupt masking: only channel 2 drives irq
    do_reset();
    presc = 16'd0; en = 4'b1111; irq_en = 4'b0100;
    reload = {32'd1, 32'd5, 32'd1, 32'd1};
    load = 4'b1111;
    step(1);
    load = '0;
    step(2);
    check("irq_others_exp", 128'(expired), 128'(4'b1011));
    check("irq_masked_low", 128'(irq), 128'(0));
    step(3);
    check("irq_still_low", 128'(irq), 128'(0));
    step(1);
    check("irq_all_exp", 128'(expired), 128'(4'b1111));
    check("irq_raised", 128'(irq), 128'(1));
    irq_ack = 4'b0100; step(1); irq_ack = '0;
    check("irq_dropped", 128'(irq), 128'(0));
    check("irq_others_kept", 128'(expired), 128'(4'b1011));

    // Soft reset is gated by cke; async reset acts immediately
    reload = {4{32'd50}}; load = 4'b1111;
    step(1);
    load = '0;
    step(3);
    soft_rst = 1'b1; cke = 1'b0;
    step(1);
    check("soft_rst_gated", 128'(count[0 +: 32]), 128'(47));
    cke = 1'b1;
    step(1);
    soft_rst = 1'b0;
    check("soft_rst_count", 128'(count), 128'(0));
    check("soft_rst_expired", 128'(expired), 128'(0));
    load = 4'b1111;
    step(1);
    load = '0;
    step(2);
    check("pre_arst_count", 128'(count[0 +: 32]), 128'(48));
    arst = 1'b1;
    #1;
    check("arst_immediate", 128'(count), 128'(0));
    arst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
